// File: rtl/seat_selector_if.sv
// Seat selector bus: mouse buttons, remote claim and round control in; seat status out.
interface seat_selector_if #(
    parameter int unsigned SEAT_W = 2
);
    logic              left_mouse;
    logic              right_mouse;
    logic              remote_valid;
    logic [SEAT_W-1:0] remote_seat;
    logic              release_seat;
    logic [SEAT_W-1:0] selected_seat;
    logic              seat_locked;
    logic              browsing;
    logic [SEAT_W-1:0] highlight_seat;
    logic              seat_conflict;

    // Driver side: mouse controller, UART link and game-flow FSM
    modport master (
        output left_mouse, right_mouse, remote_valid, remote_seat, release_seat,
        input  selected_seat, seat_locked, browsing, highlight_seat, seat_conflict
    );

    // Selector side
    modport slave (
        input  left_mouse, right_mouse, remote_valid, remote_seat, release_seat,
        output selected_seat, seat_locked, browsing, highlight_seat, seat_conflict
    );
endinterface

// File: rtl/seat_selector.sv
// Local seat selection for the blackjack table: browse free seats with right click,
// lock with left click or browse timeout, and steer clear of the remote console's seat.
module seat_selector #(
    parameter int unsigned NUM_SEATS      = 4,
    parameter int unsigned SEAT_W         = 2,
    parameter int unsigned TIMEOUT_CYCLES = 65_000_000,
    parameter int unsigned TMR_W          = 26
) (
    input  logic          clk,
    input  logic          rst,
    seat_selector_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BROWSE = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t            state;
    logic              left_prev;
    logic              right_prev;
    logic [TMR_W-1:0]  timer;
    logic              rclaim_vld;
    logic [SEAT_W-1:0] rclaim_seat;

    logic              l_edge;
    logic              r_edge;
    logic              claim_vld_nxt;
    logic [SEAT_W-1:0] claim_seat_nxt;
    logic [SEAT_W-1:0] first_free;
    logic [SEAT_W-1:0] hl_next_free;
    logic [SEAT_W-1:0] hl_eff;
    logic              hl_hit;
    logic              timeout;

    // First seat after s (wrapping modulo NUM_SEATS) not held by the remote claim
    function automatic logic [SEAT_W-1:0] free_after(
        input logic [SEAT_W-1:0] s,
        input logic              vld,
        input logic [SEAT_W-1:0] claimed
    );
        logic [SEAT_W-1:0] r;
        int unsigned       cand;
        r = s;
        for (int i = int'(NUM_SEATS); i >= 1; i--) begin
            cand = 32'(s) + 32'(i);
            if (cand >= NUM_SEATS) cand = cand - NUM_SEATS;
            if (!(vld && (SEAT_W'(cand) == claimed))) r = SEAT_W'(cand);
        end
        return r;
    endfunction

    // Button edges and the remote claim as it will stand after this cycle
    always_comb begin
        l_edge         = bus.left_mouse  & ~left_prev;
        r_edge         = bus.right_mouse & ~right_prev;
        claim_vld_nxt  = rclaim_vld;
        claim_seat_nxt = rclaim_seat;
        if (bus.release_seat) begin
            claim_vld_nxt = 1'b0;
        end else if (bus.remote_valid && (32'(bus.remote_seat) < NUM_SEATS)) begin
            claim_vld_nxt  = 1'b1;
            claim_seat_nxt = bus.remote_seat;
        end
    end

    // Free-seat search, highlight displacement by a fresh claim, and browse timeout
    always_comb begin
        first_free   = free_after(SEAT_W'(NUM_SEATS - 1), claim_vld_nxt, claim_seat_nxt);
        hl_next_free = free_after(bus.highlight_seat, claim_vld_nxt, claim_seat_nxt);
        hl_hit       = claim_vld_nxt && (claim_seat_nxt == bus.highlight_seat);
        hl_eff       = hl_hit ? hl_next_free : bus.highlight_seat;
        timeout      = (timer == TMR_W'(TIMEOUT_CYCLES - 1));
    end

    // Selector FSM with outputs registered from next-state values
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            left_prev          <= 1'b0;
            right_prev         <= 1'b0;
            timer              <= '0;
            rclaim_vld         <= 1'b0;
            rclaim_seat        <= '0;
            bus.selected_seat  <= '0;
            bus.seat_locked    <= 1'b0;
            bus.browsing       <= 1'b0;
            bus.highlight_seat <= '0;
            bus.seat_conflict  <= 1'b0;
        end else begin
            left_prev   <= bus.left_mouse;
            right_prev  <= bus.right_mouse;
            rclaim_vld  <= claim_vld_nxt;
            rclaim_seat <= claim_seat_nxt;
            if (bus.release_seat) begin
                state              <= IDLE;
                timer              <= '0;
                bus.selected_seat  <= '0;
                bus.seat_locked    <= 1'b0;
                bus.browsing       <= 1'b0;
                bus.highlight_seat <= '0;
                bus.seat_conflict  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (l_edge) begin
                            state             <= LOCKED;
                            bus.selected_seat <= first_free;
                            bus.seat_locked   <= 1'b1;
                            bus.seat_conflict <= 1'b0;
                        end else if (r_edge) begin
                            state              <= BROWSE;
                            bus.browsing       <= 1'b1;
                            bus.highlight_seat <= first_free;
                            timer              <= '0;
                        end
                    end
                    BROWSE: begin
                        if (l_edge || (!r_edge && timeout)) begin
                            state              <= LOCKED;
                            bus.selected_seat  <= hl_eff;
                            bus.seat_locked    <= 1'b1;
                            bus.browsing       <= 1'b0;
                            bus.highlight_seat <= '0;
                            bus.seat_conflict  <= claim_vld_nxt && (claim_seat_nxt == hl_eff);
                            timer              <= '0;
                        end else if (r_edge) begin
                            bus.highlight_seat <= hl_next_free;
                            timer              <= '0;
                        end else begin
                            bus.highlight_seat <= hl_eff;
                            if (timer != '1) timer <= timer + TMR_W'(1);
                        end
                    end
                    LOCKED: begin
                        bus.seat_conflict <= claim_vld_nxt && (claim_seat_nxt == bus.selected_seat);
                    end
                    default: begin
                        state              <= IDLE;
                        timer              <= '0;
                        bus.selected_seat  <= '0;
                        bus.seat_locked    <= 1'b0;
                        bus.browsing       <= 1'b0;
                        bus.highlight_seat <= '0;
                        bus.seat_conflict  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seat_selector.sv
// Scoreboard bench for seat_selector: a 4-seat and a 3-seat instance, short timeout.
module tb_seat_selector;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seat_selector_if #(.SEAT_W(2)) bus4 ();
    seat_selector_if #(.SEAT_W(2)) bus3 ();

    seat_selector #(.NUM_SEATS(4), .SEAT_W(2), .TIMEOUT_CYCLES(8), .TMR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    seat_selector #(.NUM_SEATS(3), .SEAT_W(2), .TIMEOUT_CYCLES(8), .TMR_W(4)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    typedef struct packed {
        logic [1:0] sel;
        logic       lk;
        logic       br;
        logic [1:0] hl;
        logic       cf;
    } outs_t;

    outs_t exp_q[$];
    outs_t obs_q[$];
    int    checks = 0;
    int    errors = 0;

    function automatic outs_t o(input logic [1:0] sel, input logic lk, input logic br,
                                input logic [1:0] hl, input logic cf);
        outs_t v;
        v.sel = sel; v.lk = lk; v.br = br; v.hl = hl; v.cf = cf;
        return v;
    endfunction

    localparam outs_t Z = '0;

    // Drive one cycle of stimulus on both instances, queue the reference, capture one instance
    task automatic cyc(input logic r_st, input logic l, input logic r, input logic rv,
                       input logic [1:0] rs, input logic rel, input outs_t e, input bit use3);
        rst = r_st;
        bus4.left_mouse = l; bus4.right_mouse = r; bus4.remote_valid = rv;
        bus4.remote_seat = rs; bus4.release_seat = rel;
        bus3.left_mouse = l; bus3.right_mouse = r; bus3.remote_valid = rv;
        bus3.remote_seat = rs; bus3.release_seat = rel;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (use3)
            obs_q.push_back(o(bus3.selected_seat, bus3.seat_locked, bus3.browsing,
                              bus3.highlight_seat, bus3.seat_conflict));
        else
            obs_q.push_back(o(bus4.selected_seat, bus4.seat_locked, bus4.browsing,
                              bus4.highlight_seat, bus4.seat_conflict));
    endtask

    task automatic idle(input int n, input outs_t e, input bit use3);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, e, use3);
    endtask

    task automatic test_reset();
        outs_t e, g;
        int n = 0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, Z, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, Z, 1'b0);
        idle(2, Z, 1'b0);
        idle(1, Z, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = obs_q.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL reset step %0d: got sel=%0d lk=%b br=%b hl=%0d cf=%b, want sel=%0d lk=%b br=%b hl=%0d cf=%b",
                         n, g.sel, g.lk, g.br, g.hl, g.cf, e.sel, e.lk, e.br, e.hl, e.cf);
            end
            n++;
        end
    endtask

    task automatic test_left_hold();
        outs_t e, g;
        int n = 0;
        idle(4, Z, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, o(0, 1, 0, 0, 0), 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, o(0, 1, 0, 0, 0), 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, Z, 1'b0);
        idle(1, Z, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = obs_q.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL left_hold step %0d: got sel=%0d lk=%b br=%b hl=%0d cf=%b, want sel=%0d lk=%b br=%b hl=%0d cf=%b",
                         n, g.sel, g.lk, g.br, g.hl, g.cf, e.sel, e.lk, e.br, e.hl, e.cf);
            end
            n++;
        end
    endtask

    task automatic test_browse_wrap();
        outs_t e, g;
        int n = 0;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, Z, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, o(0, 0, 1, 1, 0), 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, o(0, 0, 1, 1, 0), 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, o(0, 0, 1, 2, 0), 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, o(0, 0, 1, 2, 0), 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, o(0, 0, 1, 3, 0), 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, o(0, 0, 1, 3, 0), 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, o(0, 0, 1, 1, 0), 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, o(0, 0, 1, 1, 0), 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, o(1, 1, 0, 0, 0), 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, o(1, 1, 0, 0, 0), 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, Z, 1'b0);
        idle(1, Z, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = obs_q.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL browse_wrap step %0d: got sel=%0d lk=%b br=%b hl=%0d cf=%b, want sel=%0d lk=%b br=%b hl=%0d cf=%b",
                         n, g.sel, g.lk, g.br, g.hl, g.cf, e.sel, e.lk, e.br, e.hl, e.cf);
            end
            n++;
        end
    endtask

    task automatic test_timeout();
        outs_t e, g;
        int n = 0;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, o(0, 0, 1, 0, 0), 1'b0);
        idle(7, o(0, 0, 1, 0, 0), 1'b0);
        idle(1, o(0, 1, 0, 0, 0), 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, Z, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, o(0, 0, 1, 0, 0), 1'b0);
        idle(4, o(0, 0, 1, 0, 0), 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, o(0, 0, 1, 1, 0), 1'b0);
        idle(7, o(0, 0, 1, 1, 0), 1'b0);
        idle(1, o(1, 1, 0, 0, 0), 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, Z, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = obs_q.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL timeout step %0d: got sel=%0d lk=%b br=%b hl=%0d cf=%b, want sel=%0d lk=%b br=%b hl=%0d cf=%b",
                         n, g.sel, g.lk, g.br, g.hl, g.cf, e.sel, e.lk, e.br, e.hl, e.cf);
            end
            n++;
        end
    endtask

    task automatic test_remote_claim();
        outs_t e, g;
        int n = 0;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, o(0, 0, 1, 0, 0), 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, o(0, 0, 1, 0, 0), 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, o(0, 0, 1, 1, 0), 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, o(0, 0, 1, 1, 0), 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, o(0, 0, 1, 2, 0), 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, o(0, 0, 1, 2, 0), 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, o(0, 0, 1, 3, 0), 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, o(0, 0, 1, 0, 0), 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, o(0, 0, 1, 0, 0), 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, o(0, 0, 1, 1, 0), 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, o(0, 0, 1, 1, 0), 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, o(1, 1, 0, 0, 0), 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, o(1, 1, 0, 0, 0), 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, o(1, 1, 0, 0, 1), 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, o(1, 1, 0, 0, 1), 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, o(1, 1, 0, 0, 0), 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, Z, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = obs_q.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL remote_claim step %0d: got sel=%0d lk=%b br=%b hl=%0d cf=%b, want sel=%0d lk=%b br=%b hl=%0d cf=%b",
                         n, g.sel, g.lk, g.br, g.hl, g.cf, e.sel, e.lk, e.br, e.hl, e.cf);
            end
            n++;
        end
    endtask

    task automatic test_back_to_back();
        outs_t e, g;
        int n = 0;
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, o(0, 1, 0, 0, 0), 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, o(0, 1, 0, 0, 0), 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, Z, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, Z, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, Z, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, o(0, 0, 1, 0, 0), 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, Z, 1'b0);
        idle(1, Z, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = obs_q.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL back_to_back step %0d: got sel=%0d lk=%b br=%b hl=%0d cf=%b, want sel=%0d lk=%b br=%b hl=%0d cf=%b",
                         n, g.sel, g.lk, g.br, g.hl, g.cf, e.sel, e.lk, e.br, e.hl, e.cf);
            end
            n++;
        end
    endtask

    task automatic test_reset_mid_browse();
        outs_t e, g;
        int n = 0;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, o(0, 0, 1, 0, 0), 1'b0);
        idle(6, o(0, 0, 1, 0, 0), 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, Z, 1'b0);
        idle(10, Z, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = obs_q.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL reset_mid_browse step %0d: got sel=%0d lk=%b br=%b hl=%0d cf=%b, want sel=%0d lk=%b br=%b hl=%0d cf=%b",
                         n, g.sel, g.lk, g.br, g.hl, g.cf, e.sel, e.lk, e.br, e.hl, e.cf);
            end
            n++;
        end
    endtask

    task automatic test_three_seats();
        outs_t e, g;
        int n = 0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, Z, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, o(0, 0, 1, 0, 0), 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, o(0, 0, 1, 0, 0), 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, o(0, 0, 1, 1, 0), 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, o(0, 0, 1, 1, 0), 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, o(0, 0, 1, 2, 0), 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, o(0, 0, 1, 2, 0), 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, o(0, 0, 1, 0, 0), 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, o(0, 0, 1, 0, 0), 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, o(0, 0, 1, 0, 0), 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, o(0, 0, 1, 1, 0), 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, o(0, 0, 1, 1, 0), 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, o(1, 1, 0, 0, 0), 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, o(1, 1, 0, 0, 0), 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, Z, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = obs_q.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL three_seats step %0d: got sel=%0d lk=%b br=%b hl=%0d cf=%b, want sel=%0d lk=%b br=%b hl=%0d cf=%b",
                         n, g.sel, g.lk, g.br, g.hl, g.cf, e.sel, e.lk, e.br, e.hl, e.cf);
            end
            n++;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus4.left_mouse = 1'b0; bus4.right_mouse = 1'b0; bus4.remote_valid = 1'b0;
        bus4.remote_seat = '0;  bus4.release_seat = 1'b0;
        bus3.left_mouse = 1'b0; bus3.right_mouse = 1'b0; bus3.remote_valid = 1'b0;
        bus3.remote_seat = '0;  bus3.release_seat = 1'b0;
        test_reset();
        test_left_hold();
        test_browse_wrap();
        test_timeout();
        test_remote_claim();
        test_back_to_back();
        test_reset_mid_browse();
        test_three_seats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seat_selector.md
Name: seat_selector

Overview:
- Parametrised successor to the two-way player selector. Assigns the local console one of NUM_SEATS table seats at the blackjack table, chosen with mouse buttons.
- Right click browses free seats. Left click locks the highlighted seat. An idle browse auto-locks after a timeout.
- Tracks a seat claimed by the remote console over the UART link, so both consoles never take the same seat.
- Sits between the mouse controller and the game-flow state machine. Its outputs also drive the seat highlight overlay in the draw path.

Parameters:
- NUM_SEATS, 4, number of table seats; legal range 2..8.
- SEAT_W, 2, seat index width; must equal $clog2(NUM_SEATS).
- TIMEOUT_CYCLES, 65_000_000, browse inactivity cycles before auto-lock (1 s at 65 MHz); must be >= 2.
- TMR_W, 26, timer width; must satisfy 2**TMR_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  posedge clock.
- rst  input  1  synchronous, active-high reset.
- left_mouse  input  1  left button level, synchronous to clk.
- right_mouse  input  1  right button level, synchronous to clk.
- remote_valid  input  1  one-cycle pulse: remote console claims remote_seat.
- remote_seat  input  SEAT_W  seat index claimed by the remote console.
- release_seat  input  1  one-cycle pulse at round end that frees all seats.
- selected_seat  output  SEAT_W  locked seat index; valid while seat_locked=1.
- seat_locked  output  1  local seat is locked.
- browsing  output  1  FSM is in BROWSE.
- highlight_seat  output  SEAT_W  seat currently highlighted during browse.
- seat_conflict  output  1  remote claim equals the locked local seat.

Behaviour:
- Reset (rst=1 at posedge):
  - All outputs go to 0.
  - FSM goes to IDLE; timer clears to 0; remote claim becomes invalid; button history registers clear to 0.
  - Reset mid-browse or while locked aborts immediately. No auto-lock fires.
- Edge detect:
  - l_edge = left_mouse & ~left_prev; r_edge = right_mouse & ~right_prev.
  - History registers sample every cycle.
  - A held button produces exactly one edge.
- Remote claim register:
  - On remote_valid, rclaim_seat <= remote_seat and rclaim_vld <= 1. A later claim overwrites the earlier one.
  - remote_seat >= NUM_SEATS is ignored.
  - A seat is free when it is not (rclaim_vld && seat == rclaim_seat).
  - Free-seat search uses the claim value after this cycle's update.
- free_after(s): first free seat scanning s+1, s+2, ... modulo NUM_SEATS. With at most one claim, a free seat always exists. first_free = free_after(NUM_SEATS-1).
- FSM states: IDLE, BROWSE, LOCKED.
  - IDLE, l_edge: go to LOCKED; selected = first_free.
  - IDLE, r_edge only: go to BROWSE; highlight = first_free; timer = 0.
  - BROWSE, l_edge: go to LOCKED; selected = highlight. Left wins over a simultaneous right.
  - BROWSE, r_edge only: highlight = free_after(highlight); timer = 0.
  - BROWSE, remote claim hits the highlighted seat: highlight = free_after(highlight). This happens in the same cycle as the claim, and the timer is not reset.
  - BROWSE, no edge: timer increments. When timer == TIMEOUT_CYCLES-1, go to LOCKED with selected = highlight. An l_edge in that same cycle gives the identical result.
  - LOCKED: holds until release_seat.
  - A remote claim on the locked seat does not move the local seat. seat_conflict = 1 while rclaim_seat == selected_seat && rclaim_vld.
  - release_seat in any state: go to IDLE, clear rclaim_vld, clear all outputs. It has priority over button edges in the same cycle.
  - Illegal state encoding: go to IDLE.
- Output registers:
  - All outputs are registered from next-state values, so they update on the same posedge the FSM transitions (zero extra cycles after the edge is sampled).
  - highlight_seat is 0 outside BROWSE.
  - selected_seat is 0 when not locked.
  - browsing = (next state == BROWSE).
- Arithmetic: all seat arithmetic is modulo NUM_SEATS (wrap from NUM_SEATS-1 to 0, including non-power-of-two NUM_SEATS). The timer saturates and never wraps.

Test Plan:
1. Reset, then left_mouse rises at cycle 5 and is held 10 cycles -> at the cycle-5 posedge, seat_locked=1 and selected_seat=0; no further change while held.
2. remote_valid pulse with remote_seat=0, then right click -> browsing=1, highlight=1. Three more right clicks -> highlight goes 2, 3, 1 (seat 0 skipped, wrap). Left click -> selected_seat=1, seat_locked=1, browsing=0.
3. With TIMEOUT_CYCLES=8: right click, then idle -> auto-lock exactly 8 cycles after the click edge with selected_seat=0. A right click at cycle 5 restarts the count and moves highlight to 1.
4. Browsing with highlight=2, then remote_valid with remote_seat=2 -> highlight=3 on the same posedge. Next, remote_seat=1 while locked on seat 1 -> seat_conflict=1, selected_seat stays 1.
5. Left and right rise together in IDLE -> LOCKED on seat 0. release_seat together with a left edge while locked -> IDLE, all outputs 0.
6. rst asserted for 1 cycle mid-browse at timer=6 -> all outputs 0, no auto-lock. Repeat with NUM_SEATS=3, SEAT_W=2: four right clicks wrap highlight 0, 1, 2, 0.
